relu_pool_y: RTL and testbench
==============================

RELU_POOL_Y -- requirements
Module: relu_pool_y

Interface
REQ-001 Parameter WIDTH, 18: signed sample width on the input and output streams.
REQ-002 Parameter FRAME_LEN, 5: y samples per convolution frame (8-tap input, 4-tap filter: 8-4+1).
REQ-003 Parameter POOL, 2: samples combined per pooled output.
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 s_data_in_y  input  WIDTH signed  convolution output sample.
REQ-007 s_valid_y  input  1  upstream sample valid.
REQ-008 s_ready_y  output  1  block accepts a sample this cycle.
REQ-009 m_data_out_z  output  WIDTH signed  pooled, rectified result.
REQ-010 m_valid_z  output  1  m_data_out_z valid.
REQ-011 m_ready_z  input  1  downstream accepts a result this cycle.

Function
REQ-012 Input transfer occurs when s_valid_y && s_ready_y; output transfer occurs when m_valid_z && m_ready_z.
REQ-013 Each accepted sample is rectified: r = (y < 0) ? 0 : y; full WIDTH is kept, with no truncation.
REQ-014 Frame index counter fidx counts accepted samples 0..FRAME_LEN-1 and wraps to 0 after FRAME_LEN-1.
REQ-015 The pair FSM has two states, EMPTY and HALF:
  - EMPTY + accept, not last of frame: latch r into hold, go to HALF.
  - EMPTY + accept, last of frame: push r alone, stay EMPTY.
  - HALF + accept: push max(hold, r), go to EMPTY.
REQ-016 Pooling never spans a frame boundary, so a FRAME_LEN=5 frame yields exactly 3 results: max(r0,r1), max(r2,r3), r4.
REQ-017 Results enter a 2-entry FIFO; m_valid_z = (FIFO count != 0); m_data_out_z = FIFO head.
REQ-018 Latency: a result is presented on m_data_out_z/m_valid_z in the cycle after the accept that completes it.
REQ-019 s_ready_y = !reset && (FIFO count < 2); there is no combinational path from m_ready_z to s_ready_y.
REQ-020 Push and pop in the same cycle leave the count unchanged and preserve order.
REQ-021 While m_valid_z=1 and m_ready_z=0, m_data_out_z shall hold stable.
REQ-022 Gaps in s_valid_y, at any position including mid-pair, shall not alter results.

Reset
REQ-023 While reset=1 the following values shall apply asynchronously:
  - FIFO count=0, m_valid_z=0, m_data_out_z=0;
  - fidx=0, FSM=EMPTY, hold=0;
  - s_ready_y=0.
REQ-024 Reset mid-pair or mid-frame shall discard the partial pair and all buffered results; the first accept after release is sample 0 of a new frame.
REQ-025 s_ready_y shall be 1 in the first cycle after reset is released.

Structure
REQ-026 Shared package conv_pkg shall hold WIDTH_Y=18, FRAME_LEN=5, POOL=2 and the pair-state enum {EMPTY, HALF}.
REQ-027 The output buffer shall be a sub-module fifo_2 (2-entry, WIDTH-parametrised, valid/ready on both sides, asynchronous reset).
REQ-028 Total RTL shall be 120-400 lines.

Verification
REQ-029 Frame 5, -3, 7, 2, -9 with m_ready_z=1 -> outputs 5, 7, 0; a second frame 1, 1, 1, 1, 1 -> 1, 1, 1.
REQ-030 Frame -1, -2, -3, -4, -5 -> 0, 0, 0.
REQ-031 Input 131071, -131072, 0, 0, -131072 -> 131071, 0, 0.
REQ-032 m_ready_z=0 while streaming -> after 2 results buffered, s_ready_y=0 and m_data_out_z holds; on release, results drain in order with no loss.
REQ-033 Accept 10, assert reset one cycle, then frame 1, 2, 3, 4, 5 -> 2, 4, 5; the 10 never appears.
REQ-034 s_valid_y toggled every other cycle and m_ready_z randomised, REQ-029 data -> identical output sequence.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution post-processing path.
package conv_pkg;

  localparam int WIDTH_Y   = 18;
  localparam int FRAME_LEN = 5;
  localparam int POOL      = 2;

  // Pair-pooling state: EMPTY = no sample held, HALF = first of a pair held.
  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pair_state_t;

endpackage

// File: rtl/fifo_2.sv
// Two-entry valid/ready FIFO with asynchronous reset.
// Handshake: a transfer happens on a side when its valid and ready are both 1
// at the rising clock edge; s_ready depends only on the stored count, never on
// m_ready, so there is no combinational path through the buffer.
module fifo_2 #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign s_ready = (count_q != 2'd2);
  assign m_valid = (count_q != 2'd0);
  assign m_data  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    push     = s_valid && s_ready;
    pop      = m_valid && m_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Register FIFO state; reset clears contents so the head reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/relu_pool_y.sv
// Rectify each convolution output sample and max-pool pairs within a frame.
// A frame of FRAME_LEN samples is pooled pairwise; an odd trailing sample is
// emitted on its own so pooling never straddles two frames.
// Handshake: input accepted when s_valid_y && s_ready_y, result taken when
// m_valid_z && m_ready_z; s_ready_y is a function of buffer occupancy only.
module relu_pool_y
  import conv_pkg::*;
#(
  parameter int WIDTH     = WIDTH_Y,
  parameter int FRAME_LEN = conv_pkg::FRAME_LEN,
  parameter int POOL      = conv_pkg::POOL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  output logic signed [WIDTH-1:0] m_data_out_z,
  output logic                    m_valid_z,
  input  logic                    m_ready_z,
  output pair_state_t             dbg_pair_state
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  // The pair FSM below implements two-sample pooling only.
  if (POOL != 2) begin : g_pool_unsupported
  end

  pair_state_t             state_q, state_d;
  logic        [FW-1:0]    fidx_q, fidx_d;
  logic signed [WIDTH-1:0] hold_q, hold_d;
  logic signed [WIDTH-1:0] rect;
  logic signed [WIDTH-1:0] push_data;
  logic                    push;
  logic                    accept;
  logic                    last_of_frame;
  logic                    fifo_s_ready;
  logic        [WIDTH-1:0] fifo_m_data;

  assign s_ready_y      = !reset && fifo_s_ready;
  assign accept         = s_valid_y && s_ready_y;
  assign rect           = s_data_in_y[WIDTH-1] ? '0 : s_data_in_y;
  assign last_of_frame  = (fidx_q == FW'(FRAME_LEN - 1));
  assign dbg_pair_state = state_q;
  assign m_data_out_z   = $signed(fifo_m_data);

  // Frame position, pair state and the pooled value to push on this accept.
  always_comb begin
    state_d   = state_q;
    fidx_d    = fidx_q;
    hold_d    = hold_q;
    push      = 1'b0;
    push_data = rect;
    if (accept) begin
      fidx_d = last_of_frame ? '0 : fidx_q + FW'(1);
      case (state_q)
        EMPTY: begin
          if (last_of_frame) begin
            push = 1'b1;
          end else begin
            hold_d  = rect;
            state_d = HALF;
          end
        end
        HALF: begin
          push      = 1'b1;
          push_data = (rect > hold_q) ? rect : hold_q;
          state_d   = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Register pair state, held sample and frame index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      fidx_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      hold_q  <= hold_d;
    end
  end

  fifo_2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .s_data  (push_data),
    .s_valid (push),
    .s_ready (fifo_s_ready),
    .m_data  (fifo_m_data),
    .m_valid (m_valid_z),
    .m_ready (m_ready_z)
  );

endmodule

// File: tb/tb_relu_pool_y.sv
// Directed bench for relu_pool_y with a frame-level reference model.
module tb_relu_pool_y;
  import conv_pkg::*;

  localparam int W = WIDTH_Y;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] s_data_in_y = '0;
  logic         s_valid_y = 1'b0;
  logic         s_ready_y;
  logic [W-1:0] m_data_out_z;
  logic         m_valid_z;
  logic         m_ready_z = 1'b1;
  pair_state_t  dbg_pair_state;

  always #5 clk = ~clk;

  relu_pool_y dut (
    .clk            (clk),
    .reset          (reset),
    .s_data_in_y    (s_data_in_y),
    .s_valid_y      (s_valid_y),
    .s_ready_y      (s_ready_y),
    .m_data_out_z   (m_data_out_z),
    .m_valid_z      (m_valid_z),
    .m_ready_z      (m_ready_z),
    .dbg_pair_state (dbg_pair_state)
  );

  // ---------------- scoreboard state ----------------
  int           n_vec  = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_log[$];
  int           frame_pos = 0;
  int           grp_max   = 0;
  bit           held      = 1'b0;
  logic [W-1:0] held_val  = '0;
  int           rdy_mode  = 0;   // 0: always ready, 1: never ready, 2: random

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rectify, group samples POOL at a time inside a frame,
  // emit the group maximum when the group fills or the frame ends.
  task automatic model_accept(input logic [W-1:0] y);
    int v, r;
    v = int'($signed(y));
    r = (v < 0) ? 0 : v;
    if (frame_pos % POOL == 0) grp_max = r;
    else if (r > grp_max) grp_max = r;
    if ((frame_pos % POOL == POOL - 1) || (frame_pos == FRAME_LEN - 1))
      exp_q.push_back(W'(grp_max));
    frame_pos = (frame_pos + 1) % FRAME_LEN;
  endtask

  // Compare process: outputs are checked mid-cycle against the model.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_m_valid", int'(m_valid_z), 0);
      check("rst_m_data", int'(m_data_out_z), 0);
      check("rst_s_ready", int'(s_ready_y), 0);
      check("rst_state", int'(dbg_pair_state), int'(EMPTY));
      exp_q.delete();
      frame_pos = 0;
      held      = 1'b0;
    end else begin
      check("m_valid", int'(m_valid_z), int'(exp_q.size() != 0));
      check("s_ready", int'(s_ready_y), int'(exp_q.size() < 2));
      if (m_valid_z && exp_q.size() != 0)
        check("m_data", int'(m_data_out_z), int'(exp_q[0]));
      if (held)
        check("hold_stable", int'(m_data_out_z), int'(held_val));
      held     = m_valid_z && !m_ready_z;
      held_val = m_data_out_z;
      if (m_valid_z && m_ready_z && exp_q.size() != 0) begin
        out_log.push_back(m_data_out_z);
        void'(exp_q.pop_front());
      end
      if (s_valid_y && s_ready_y) model_accept(s_data_in_y);
    end
  end

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready_z = 1'b1;
        1:       m_ready_z = 1'b0;
        default: m_ready_z = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int v, input int gap);
    int t;
    s_data_in_y = W'(v);
    s_valid_y   = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_ready_y) break;
    end
    check("send_timeout", int'(t < 200), 1);
    @(posedge clk);
    #1;
    s_valid_y = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int v0, v1, v2, v3, v4, input int gap);
    send(v0, gap); send(v1, gap); send(v2, gap); send(v3, gap); send(v4, gap);
  endtask

  task automatic drain();
    int t;
    rdy_mode = 0;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid_z) break;
    end
    check("drain_timeout", int'(t < 100), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input logic [W-1:0] exp_vals[$]);
    check({name, "_count"}, out_log.size(), exp_vals.size());
    for (int i = 0; i < exp_vals.size() && i < out_log.size(); i++)
      check(name, int'(out_log[i]), int'(exp_vals[i]));
    out_log.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] lit[$];
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Mixed-sign frame followed by an all-ones frame.
    send_frame(5, -3, 7, 2, -9, 0);
    send_frame(1, 1, 1, 1, 1, 0);
    drain();
    lit = '{5, 7, 0, 1, 1, 1};
    check_log("basic", lit);

    // All-negative frame rectifies to zeros.
    send_frame(-1, -2, -3, -4, -5, 0);
    drain();
    lit = '{0, 0, 0};
    check_log("negative", lit);

    // Extremes of the signed range.
    send_frame(131071, -131072, 0, 0, -131072, 0);
    drain();
    lit = '{131071, 0, 0};
    check_log("extremes", lit);

    // Back-pressure: two results fill the buffer, input stalls, head holds.
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send(5, 0); send(-3, 0); send(7, 0); send(2, 0);
    repeat (3) @(negedge clk);
    check("full_s_ready", int'(s_ready_y), 0);
    check("full_head", int'(m_data_out_z), 5);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send(-9, 0);
    drain();
    lit = '{5, 7, 0};
    check_log("backpressure", lit);

    // Reset mid-pair discards the pending sample.
    send(10, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", int'(s_ready_y), 1);
    check("post_reset_state", int'(dbg_pair_state), int'(EMPTY));
    @(posedge clk);
    #1;
    send_frame(1, 2, 3, 4, 5, 0);
    drain();
    lit = '{2, 4, 5};
    check_log("reset_mid_pair", lit);

    // Gapped input with random downstream ready.
    rdy_mode = 2;
    send_frame(5, -3, 7, 2, -9, 1);
    send_frame(1, 1, 1, 1, 1, 1);
    drain();
    lit = '{5, 7, 0, 1, 1, 1};
    check_log("gapped_random", lit);

    check("final_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
